// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and default width for the counter family
package counter_pkg;

  localparam int COUNTER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/counter_down_load.sv
// rtl/counter_down_load.sv - loadable down-counter/timer with one-shot and auto-reload modes
module counter_down_load
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cnt_state_e       state, state_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             zero_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      zero       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      zero       <= zero_n;
      busy       <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    zero_n   = 1'b0;
    if (load) begin
      count_n  = data;
      reload_n = data;
      state_n  = (data != '0) ? RUN : IDLE;
    end else begin
      case (state)
        RUN, PAUSE: begin
          if (!en) begin
            state_n = PAUSE;
          end else if (count == ONE) begin
            zero_n = 1'b1;
            if (auto_reload) begin
              count_n = reload_reg;
              state_n = RUN;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end else if (count != '0) begin
            count_n = count - ONE;
            state_n = RUN;
          end else begin
            // A zero count while active can only come from a corrupted state; park safely.
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_down_load.sv
// tb/tb_counter_down_load.sv - randomized self-checking bench for counter_down_load
module tb_counter_down_load;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = '0;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] count;
  logic       zero;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Reference model: an active flag plus arithmetic on the count, no state machine
  logic [7:0] m_count = '0;
  logic [7:0] m_reload = '0;
  logic       m_zero = 1'b0;
  logic       m_active = 1'b0;

  counter_down_load #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .data(data), .load(load), .en(en),
    .auto_reload(auto_reload), .count(count), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic ld, input logic [7:0] d,
                      input logic e, input logic ar);
    rst = r; load = ld; data = d; en = e; auto_reload = ar;
    @(posedge clk);
    if (r) begin
      m_count = 0; m_reload = 0; m_zero = 0; m_active = 0;
    end else if (ld) begin
      m_count = d; m_reload = d; m_zero = 0; m_active = (d != 0);
    end else if (m_active && e) begin
      if (m_count == 1) begin
        m_zero = 1;
        if (ar) m_count = m_reload;
        else begin m_count = 0; m_active = 0; end
      end else begin
        m_count = m_count - 1; m_zero = 0;
      end
    end else begin
      m_zero = 0;
    end
    #1;
  endtask

  task automatic test_reset;
    int zero_seen = 0;
    tick(1, 0, 0, 0, 0);
    checks++;
    if ({count, zero, busy} !== 10'b0) begin
      failures++; $display("FAIL reset_state got=%h/%b/%b exp=00/0/0", count, zero, busy);
    end
    tick(0, 1, 8'h3e, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 0);
    checks++;
    if (count !== 8'd52) begin
      failures++; $display("FAIL reset_precount got=%0d exp=52", count);
    end
    tick(1, 0, 0, 1, 0);
    checks++;
    if ({count, zero, busy} !== 10'b0) begin
      failures++; $display("FAIL reset_midcount got=%h/%b/%b exp=00/0/0", count, zero, busy);
    end
    for (int i = 0; i < 70; i++) begin
      tick(0, 0, 0, 1, 0);
      if (zero !== 1'b0 || count !== 8'd0) zero_seen++;
    end
    checks++;
    if (zero_seen != 0) begin
      failures++; $display("FAIL reset_no_later_zero got=%0d bad_cycles exp=0", zero_seen);
    end
  endtask

  task automatic test_one_shot;
    tick(0, 1, 8'h3e, 1, 0);
    checks++;
    if (count !== 8'd62 || busy !== 1'b1) begin
      failures++; $display("FAIL oneshot_load got=%0d/%b exp=62/1", count, busy);
    end
    for (int i = 1; i <= 62; i++) begin
      tick(0, 0, 0, 1, 0);
      checks++;
      if ({count, zero, busy} !== {m_count, m_zero, m_active}) begin
        failures++;
        $display("FAIL oneshot_step i=%0d got=%0d/%b/%b exp=%0d/%b/%b",
                 i, count, zero, busy, m_count, m_zero, m_active);
      end
    end
    checks++;
    if ({count, zero, busy} !== {8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL oneshot_terminal got=%0d/%b/%b exp=0/1/0", count, zero, busy);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 1, 0);
      checks++;
      if (count !== 8'd0 || zero !== 1'b0) begin
        failures++; $display("FAIL oneshot_hold i=%0d got=%0d/%b exp=0/0", i, count, zero);
      end
    end
  endtask

  task automatic test_auto_reload;
    logic [7:0] exp_c;
    tick(0, 1, 8'h05, 1, 1);
    for (int i = 1; i <= 30; i++) begin
      tick(0, 0, 0, 1, 1);
      exp_c = (i % 5 == 0) ? 8'd5 : 8'(5 - i % 5);
      checks++;
      if ({count, zero, busy} !== {exp_c, (i % 5 == 0), 1'b1}) begin
        failures++;
        $display("FAIL autoreload i=%0d got=%0d/%b/%b exp=%0d/%b/1",
                 i, count, zero, busy, exp_c, (i % 5 == 0));
      end
    end
  endtask

  task automatic test_pause;
    tick(0, 1, 8'h0a, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      tick(0, 0, 0, 0, 0);
      checks++;
      if ({count, zero, busy} !== {8'd7, 1'b0, 1'b1}) begin
        failures++; $display("FAIL pause_hold i=%0d got=%0d/%b/%b exp=7/0/1", i, count, zero, busy);
      end
    end
    for (int i = 1; i <= 7; i++) begin
      tick(0, 0, 0, 1, 0);
      checks++;
      if (zero !== (i == 7) || count !== 8'(7 - i)) begin
        failures++; $display("FAIL pause_resume i=%0d got=%0d/%b exp=%0d/%b", i, count, zero, 7 - i, i == 7);
      end
    end
  endtask

  task automatic test_load_interactions;
    int zero_seen = 0;
    tick(0, 1, 8'd30, 1, 0);
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 0);
    tick(0, 1, 8'h03, 1, 0);
    checks++;
    if ({count, zero, busy} !== {8'd3, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reload_mid got=%0d/%b/%b exp=3/0/1", count, zero, busy);
    end
    for (int i = 1; i <= 3; i++) begin
      tick(0, 0, 0, 1, 0);
      checks++;
      if (zero !== (i == 3)) begin
        failures++; $display("FAIL reload_mid_term i=%0d got=%b exp=%b", i, zero, i == 3);
      end
    end
    tick(0, 1, 8'h04, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
    tick(0, 1, 8'h09, 1, 0);
    checks++;
    if ({count, zero, busy} !== {8'd9, 1'b0, 1'b1}) begin
      failures++; $display("FAIL load_on_terminal got=%0d/%b/%b exp=9/0/1", count, zero, busy);
    end
    tick(0, 1, 8'h00, 1, 1);
    checks++;
    if ({count, zero, busy} !== 10'b0) begin
      failures++; $display("FAIL load_zero got=%0d/%b/%b exp=0/0/0", count, zero, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 1, 1);
      if (zero !== 1'b0 || count !== 8'd0 || busy !== 1'b0) zero_seen++;
    end
    checks++;
    if (zero_seen != 0) begin
      failures++; $display("FAIL load_zero_idle got=%0d bad_cycles exp=0", zero_seen);
    end
  endtask

  task automatic test_wrap_guard;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 1, 0);
      checks++;
      if (count !== 8'd0 || zero !== 1'b0) begin
        failures++; $display("FAIL wrap_guard i=%0d got=%h/%b exp=00/0", i, count, zero);
      end
    end
  endtask

  task automatic test_random;
    logic       r, ld, e, ar;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 11) == 0);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      e  = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      tick(r, ld, d, e, ar);
      checks++;
      if ({count, zero, busy} !== {m_count, m_zero, m_active}) begin
        failures++;
        $display("FAIL random i=%0d got=%0d/%b/%b exp=%0d/%b/%b",
                 i, count, zero, busy, m_count, m_zero, m_active);
      end
    end
  endtask

  initial begin
    test_reset;
    test_one_shot;
    test_auto_reload;
    test_pause;
    test_load_interactions;
    test_wrap_guard;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
